// File: rtl/sram_arb_pkg.sv
// Shared owner tags, FSM encodings and access-size codes for the SRAM port arbiter.
package sram_arb_pkg;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOCK_INST = 2'd1,
    ST_LOCK_DATA = 2'd2
  } arb_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic arb_state_e lock_state(input logic owner);
    return (owner == OWNER_DATA) ? ST_LOCK_DATA : ST_LOCK_INST;
  endfunction

endpackage

// File: rtl/sram_arb_owner_fifo.sv
// 1-bit owner-tag FIFO recording who issued each accepted request, so in-order responses
// can be routed back. A separate count register gives full/empty; pointers wrap modulo DEPTH.
module sram_arb_owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic push_owner,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] slot_q, slot_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      slot_d[wr_ptr_q] = push_owner;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: tag storage is deliberately not reset; a slot is only read while count says it holds a live entry.
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  assign head  = slot_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates the instruction and data requesters onto one SRAM-like port and routes responses by owner tag.
// Macro SRAM_ARB_RR_EN selects round-robin arbitration; SRAM_ARB_ASSERT_EMPTY enables the stray-response check.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic                clk,
  input  logic                resetn,

  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,

  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,

  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_e state_q, state_d;
  logic grant_owner;
  logic grant_valid;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_head;
  logic pop;
  logic stall;
  logic accept;

`ifdef SRAM_ARB_RR_EN
  logic last_q, last_d;
`endif

  always_comb begin
    grant_owner = OWNER_DATA;
    grant_valid = 1'b0;
    case (state_q)
      ST_LOCK_INST: begin
        grant_owner = OWNER_INST;
        grant_valid = inst_req;
      end
      ST_LOCK_DATA: begin
        grant_owner = OWNER_DATA;
        grant_valid = data_req;
      end
      default: begin
        grant_valid = inst_req | data_req;
        if (inst_req && data_req) begin
`ifdef SRAM_ARB_RR_EN
          grant_owner = ~last_q;
`else
          grant_owner = OWNER_DATA;
`endif
        end else begin
          grant_owner = data_req ? OWNER_DATA : OWNER_INST;
        end
      end
    endcase
  end

  // A response popping this cycle frees a slot, so a full FIFO may still accept alongside it.
  assign pop    = mem_data_ok & ~fifo_empty;
  assign stall  = fifo_full & ~pop;
  assign mem_req = resetn & grant_valid & ~stall;
  assign accept  = mem_req & mem_addr_ok;

  assign inst_addr_ok = accept & (grant_owner == OWNER_INST);
  assign data_addr_ok = accept & (grant_owner == OWNER_DATA);
  assign inst_data_ok = pop & (fifo_head == OWNER_INST);
  assign data_data_ok = pop & (fifo_head == OWNER_DATA);
  assign inst_rdata   = resetn ? mem_rdata : '0;
  assign data_rdata   = resetn ? mem_rdata : '0;

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (resetn) begin
      if (grant_owner == OWNER_DATA) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_wstrb = inst_wstrb;
        mem_addr  = inst_addr;
        mem_wdata = inst_wdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_req && !mem_addr_ok) state_d = lock_state(grant_owner);
      end
      ST_LOCK_INST, ST_LOCK_DATA: begin
        if (accept) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef SRAM_ARB_RR_EN
  always_comb begin
    last_d = last_q;
    if (accept) last_d = grant_owner;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_q <= OWNER_INST;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  sram_arb_owner_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (accept),
    .push_owner(grant_owner),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef SRAM_ARB_ASSERT_EMPTY
  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (!(mem_data_ok && fifo_empty))
        else $error("sram_port_arbiter: mem_data_ok with no outstanding request");
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: expected owners are queued on accept and checked on response.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

`ifdef SRAM_ARB_RR_EN
  localparam logic EXP_SECOND_CONFLICT = OWNER_INST;
`else
  localparam logic EXP_SECOND_CONFLICT = OWNER_DATA;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;

  logic          inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]    inst_size;
  logic [SW-1:0] inst_wstrb;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_wdata, inst_rdata;
  logic          data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]    data_size;
  logic [SW-1:0] data_wstrb;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata, data_rdata;
  logic          mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]    mem_size;
  logic [SW-1:0] mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_q[$];

  sram_port_arbiter #(.MAX_OUTSTANDING(2), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = SIZE_WORD; inst_wstrb = '0; inst_addr = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = SIZE_WORD; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
  endtask

  // One accepted request from a single requester; owner queued for the later response.
  task automatic issue(input string tag, input logic owner, input logic [31:0] addr);
    if (owner == OWNER_DATA) begin data_req = 1; data_addr = addr; end
    else begin inst_req = 1; inst_addr = addr; end
    mem_addr_ok = 1;
    @(negedge clk);
    check({tag, "_inst_addr_ok"}, 32'(inst_addr_ok), 32'(owner == OWNER_INST));
    check({tag, "_data_addr_ok"}, 32'(data_addr_ok), 32'(owner == OWNER_DATA));
    check({tag, "_mem_addr"}, mem_addr, addr);
    exp_q.push_back(owner);
    tick();
    inst_req = 0; data_req = 0; mem_addr_ok = 0;
  endtask

  task automatic respond(input string tag, input logic [31:0] rd);
    logic owner;
    mem_data_ok = 1; mem_rdata = rd;
    @(negedge clk);
    owner = exp_q.pop_front();
    check({tag, "_inst_data_ok"}, 32'(inst_data_ok), 32'(owner == OWNER_INST));
    check({tag, "_data_data_ok"}, 32'(data_data_ok), 32'(owner == OWNER_DATA));
    check({tag, "_rdata"}, (owner == OWNER_INST) ? inst_rdata : data_rdata, rd);
    tick();
    mem_data_ok = 0; mem_rdata = '0;
  endtask

  initial begin
    idle_inputs();
    // Reset: outputs zero even with live inputs.
    inst_addr = 32'h1c00_0000; mem_rdata = 32'hffff_ffff; inst_req = 1;
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_inst_rdata", inst_rdata, 32'h0);
    tick();
    idle_inputs();
    resetn = 1;
    tick();

    // 1: single inst fetch, zero-latency accept, next-cycle response.
    inst_size = SIZE_WORD;
    issue("t1", OWNER_INST, 32'h1c00_0000);
    respond("t1_resp", 32'h0280_0c0c);

    // 2: two back-to-back conflicts.
    inst_req = 1; inst_addr = 32'h0000_1000; data_req = 1; data_addr = 32'h0000_2000; mem_addr_ok = 1;
    @(negedge clk);
    check("t2a_data_addr_ok", 32'(data_addr_ok), 32'h1);
    check("t2a_inst_addr_ok", 32'(inst_addr_ok), 32'h0);
    check("t2a_mem_addr", mem_addr, 32'h0000_2000);
    exp_q.push_back(OWNER_DATA);
    tick();
    @(negedge clk);
    check("t2b_inst_addr_ok", 32'(inst_addr_ok), 32'(EXP_SECOND_CONFLICT == OWNER_INST));
    check("t2b_data_addr_ok", 32'(data_addr_ok), 32'(EXP_SECOND_CONFLICT == OWNER_DATA));
    check("t2b_mem_addr", mem_addr, (EXP_SECOND_CONFLICT == OWNER_INST) ? 32'h0000_1000 : 32'h0000_2000);
    exp_q.push_back(EXP_SECOND_CONFLICT);
    tick();
    idle_inputs();
    respond("t2_resp0", 32'h0000_00a1);
    respond("t2_resp1", 32'h0000_00a2);

    // 3: grant locked on data while mem_addr_ok is low; inst arrives mid-lock.
    data_req = 1; data_addr = 32'h0000_3000; data_wr = 1; data_size = SIZE_HALF;
    data_wstrb = 4'b0011; data_wdata = 32'hcafe_beef;
    @(negedge clk);
    check("t3_c1_mem_req", 32'(mem_req), 32'h1);
    check("t3_c1_mem_wr", 32'(mem_wr), 32'h1);
    check("t3_c1_mem_size", 32'(mem_size), 32'(SIZE_HALF));
    check("t3_c1_mem_wstrb", 32'(mem_wstrb), 32'h3);
    check("t3_c1_mem_wdata", mem_wdata, 32'hcafe_beef);
    tick();
    inst_req = 1; inst_addr = 32'h0000_4000;
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("t3_c%0d_mem_addr", c), mem_addr, 32'h0000_3000);
      check($sformatf("t3_c%0d_inst_addr_ok", c), 32'(inst_addr_ok), 32'h0);
      tick();
    end
    mem_addr_ok = 1;
    @(negedge clk);
    check("t3_c4_data_addr_ok", 32'(data_addr_ok), 32'h1);
    check("t3_c4_inst_addr_ok", 32'(inst_addr_ok), 32'h0);
    check("t3_c4_mem_addr", mem_addr, 32'h0000_3000);
    exp_q.push_back(OWNER_DATA);
    tick();
    data_req = 0; data_wr = 0;
    @(negedge clk);
    check("t3_c5_inst_addr_ok", 32'(inst_addr_ok), 32'h1);
    check("t3_c5_mem_addr", mem_addr, 32'h0000_4000);
    exp_q.push_back(OWNER_INST);
    tick();
    idle_inputs();
    respond("t3_resp0", 32'h0000_0033);
    respond("t3_resp1", 32'h0000_0044);

    // 4: fill to depth 2, third request blocked, drain in order, then push+pop at full.
    issue("t4_a", OWNER_INST, 32'h0000_5000);
    issue("t4_b", OWNER_DATA, 32'h0000_6000);
    inst_req = 1; inst_addr = 32'h0000_7000; mem_addr_ok = 1;
    @(negedge clk);
    check("t4_full_mem_req", 32'(mem_req), 32'h0);
    check("t4_full_inst_addr_ok", 32'(inst_addr_ok), 32'h0);
    tick();
    idle_inputs();
    respond("t4_resp_inst", 32'h0000_0011);
    respond("t4_resp_data", 32'h0000_0022);
    issue("t4_c", OWNER_INST, 32'h0000_8000);
    issue("t4_d", OWNER_DATA, 32'h0000_9000);
    inst_req = 1; inst_addr = 32'h0000_a000; mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h55;
    @(negedge clk);
    begin
      logic owner;
      owner = exp_q.pop_front();
      check("t4_pp_inst_data_ok", 32'(inst_data_ok), 32'(owner == OWNER_INST));
      check("t4_pp_data_data_ok", 32'(data_data_ok), 32'(owner == OWNER_DATA));
      check("t4_pp_inst_addr_ok", 32'(inst_addr_ok), 32'h1);
      exp_q.push_back(OWNER_INST);
    end
    tick();
    mem_data_ok = 0; inst_addr = 32'h0000_b000;
    @(negedge clk);
    check("t4_still_full_mem_req", 32'(mem_req), 32'h0);
    tick();
    idle_inputs();
    respond("t4_resp_d", 32'h0000_0066);
    respond("t4_resp_pp", 32'h0000_0077);

    // 5: async reset with one outstanding and the FSM in LOCK_DATA.
    issue("t5_a", OWNER_INST, 32'h0000_c000);
    data_req = 1; data_addr = 32'h0000_b000;
    @(negedge clk);
    check("t5_lock_mem_req", 32'(mem_req), 32'h1);
    tick();
    mem_data_ok = 1; mem_rdata = 32'hdead_beef;
    #2;
    resetn = 0;
    #1;
    check("t5_rst_mem_req", 32'(mem_req), 32'h0);
    check("t5_rst_mem_addr", mem_addr, 32'h0);
    check("t5_rst_inst_data_ok", 32'(inst_data_ok), 32'h0);
    check("t5_rst_data_rdata", data_rdata, 32'h0);
    exp_q.delete();
    tick();
    idle_inputs();
    tick();
    resetn = 1;
    tick();
    mem_data_ok = 1; mem_rdata = 32'h99;
    @(negedge clk);
    check("t5_stray_inst_data_ok", 32'(inst_data_ok), 32'h0);
    check("t5_stray_data_data_ok", 32'(data_data_ok), 32'h0);
    tick();
    idle_inputs();
    issue("t5_post", OWNER_INST, 32'h0000_d000);
    respond("t5_post_resp", 32'h0000_0123);
    check("end_sb_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
